// File: rtl/disc_fifo.sv
// First-word-fall-through synchronous FIFO for the DiscReader acquisition path.
// Level counter tracks occupancy; sticky error flags and a read checksum support transfer integrity.
module disc_fifo #(
   parameter int WIDTH       = 8,
   parameter int ADDR_BITS   = 3,
   parameter int AFULL_LEVEL = (1 << ADDR_BITS) - 2,
   parameter int SUM_BITS    = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   empty,
   output logic                   full,
   output logic                   almost_full,
   output logic [ADDR_BITS:0]     level,
   output logic                   overflow,
   output logic                   underflow,
   input  logic                   err_clear,
   input  logic                   sum_clear,
   output logic [SUM_BITS-1:0]    rd_sum
);

   localparam int DEPTH   = 1 << ADDR_BITS;
   localparam int LEVEL_W = ADDR_BITS + 1;
   localparam logic [LEVEL_W-1:0] DEPTH_L = LEVEL_W'(DEPTH);
   localparam logic [LEVEL_W-1:0] AFULL_L = LEVEL_W'(AFULL_LEVEL);

   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic [ADDR_BITS-1:0] wrptr_q, wrptr_d;
   logic [ADDR_BITS-1:0] rdptr_q, rdptr_d;
   logic [LEVEL_W-1:0]   level_q, level_d;
   logic [SUM_BITS-1:0]  sum_q, sum_d;
   logic                 ovf_q, ovf_d;
   logic                 udf_q, udf_d;
   logic                 push_ok, pop_ok;

   assign empty       = (level_q == '0);
   assign full        = (level_q == DEPTH_L);
   assign almost_full = (level_q >= AFULL_L);
   assign level       = level_q;
   assign overflow    = ovf_q;
   assign underflow   = udf_q;
   assign rd_sum      = sum_q;
   assign rd_data     = empty ? '0 : mem_q[rdptr_q];

   // Pop is decided first so a full FIFO can accept a push in the same cycle.
   assign pop_ok  = rd_en && !empty && !flush;
   assign push_ok = wr_en && (!full || pop_ok) && !flush;

   always_comb begin
      wrptr_d = wrptr_q;
      rdptr_d = rdptr_q;
      level_d = level_q;
      sum_d   = sum_clear ? '0 : sum_q;
      ovf_d   = (ovf_q && !err_clear) || (wr_en && !push_ok && !flush);
      udf_d   = (udf_q && !err_clear) || (rd_en && !pop_ok && !flush);

      if (flush) begin
         wrptr_d = '0;
         rdptr_d = '0;
         level_d = '0;
         sum_d   = '0;
      end else begin
         if (push_ok) wrptr_d = wrptr_q + ADDR_BITS'(1);
         if (pop_ok) begin
            rdptr_d = rdptr_q + ADDR_BITS'(1);
            sum_d   = sum_d + SUM_BITS'(rd_data);
         end
         if (push_ok && !pop_ok)      level_d = level_q + LEVEL_W'(1);
         else if (pop_ok && !push_ok) level_d = level_q - LEVEL_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wrptr_q <= '0;
         rdptr_q <= '0;
         level_q <= '0;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         wrptr_q <= wrptr_d;
         rdptr_q <= rdptr_d;
         level_q <= level_d;
         sum_q   <= sum_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // Storage carries no reset; reset and flush only move the pointers.
   always_ff @(posedge clock) begin
      if (reset && push_ok) mem_q[wrptr_q] <= wr_data;
   end

endmodule

// File: tb/tb_disc_fifo.sv
// Directed self-checking bench for disc_fifo (default parameters: 8-bit words, depth 8).
module tb_disc_fifo;

   logic        clock = 1'b0;
   logic        reset, flush, wr_en, rd_en, err_clear, sum_clear;
   logic [7:0]  wr_data;
   logic [7:0]  rd_data;
   logic        empty, full, almost_full, overflow, underflow;
   logic [3:0]  level;
   logic [31:0] rd_sum;

   int checks = 0;
   int errors = 0;
   logic [31:0] sum_m;

   always #5 clock = ~clock;

   disc_fifo dut (
      .clock(clock), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
      .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
      .almost_full(almost_full), .level(level), .overflow(overflow),
      .underflow(underflow), .err_clear(err_clear), .sum_clear(sum_clear), .rd_sum(rd_sum)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      wr_en = 1'b1; wr_data = d;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic pop(input string tag, input logic [7:0] exp);
      check(tag, {24'd0, rd_data}, {24'd0, exp});
      rd_en = 1'b1;
      cyc();
      rd_en = 1'b0;
      sum_m = sum_m + {24'd0, exp};
   endtask

   task automatic clear_sum();
      sum_clear = 1'b1;
      cyc();
      sum_clear = 1'b0;
      sum_m = 32'd0;
   endtask

   initial begin
      reset = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      err_clear = 1'b0; sum_clear = 1'b0; wr_data = 8'h00; sum_m = 32'd0;
      #1;
      repeat (10) cyc();
      reset = 1'b1;
      cyc();
      check("rst_empty", {31'd0, empty}, 32'd1);
      check("rst_full", {31'd0, full}, 32'd0);
      check("rst_afull", {31'd0, almost_full}, 32'd0);
      check("rst_level", {28'd0, level}, 32'd0);
      check("rst_sum", rd_sum, 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);
      check("rst_udf", {31'd0, underflow}, 32'd0);
      check("rst_rdata", {24'd0, rd_data}, 32'd0);

      // five pushes on alternate clocks, then drain
      for (int i = 0; i < 5; i++) begin
         push(8'h6F);
         cyc();
      end
      check("t2_level5", {28'd0, level}, 32'd5);
      for (int i = 0; i < 5; i++) pop("t2_rdata", 8'h6F);
      check("t2_level0", {28'd0, level}, 32'd0);
      check("t2_empty", {31'd0, empty}, 32'd1);
      check("t2_sum", rd_sum, 32'd555);
      check("t2_ovf", {31'd0, overflow}, 32'd0);
      check("t2_udf", {31'd0, underflow}, 32'd0);

      // fill, overflow attempt, drain in order
      clear_sum();
      check("t3_sumclr", rd_sum, 32'd0);
      for (int i = 0; i < 8; i++) begin
         push(8'(i));
         if (i == 4) check("t3_afull_l5", {31'd0, almost_full}, 32'd0);
         if (i == 5) check("t3_afull_l6", {31'd0, almost_full}, 32'd1);
      end
      check("t3_full", {31'd0, full}, 32'd1);
      check("t3_ovf_pre", {31'd0, overflow}, 32'd0);
      push(8'hAA);
      check("t3_ovf", {31'd0, overflow}, 32'd1);
      check("t3_level", {28'd0, level}, 32'd8);
      for (int i = 0; i < 8; i++) pop("t3_rdata", 8'(i));
      check("t3_sum", rd_sum, 32'd28);
      check("t3_empty", {31'd0, empty}, 32'd1);
      err_clear = 1'b1;
      cyc();
      err_clear = 1'b0;
      check("t3_ovf_clr", {31'd0, overflow}, 32'd0);

      // simultaneous push/pop while full, with pointer wrap
      clear_sum();
      for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
      check("t4_rdata_head", {24'd0, rd_data}, 32'h10);
      rd_en = 1'b1; wr_en = 1'b1; wr_data = 8'h55;
      cyc();
      rd_en = 1'b0; wr_en = 1'b0;
      sum_m = sum_m + 32'h10;
      check("t4_level", {28'd0, level}, 32'd8);
      check("t4_ovf", {31'd0, overflow}, 32'd0);
      for (int i = 1; i < 8; i++) pop("t4_rdata", 8'h10 + 8'(i));
      pop("t4_last", 8'h55);
      check("t4_sum", rd_sum, sum_m);
      check("t4_empty", {31'd0, empty}, 32'd1);

      // underflow and empty push+pop
      rd_en = 1'b1;
      cyc();
      rd_en = 1'b0;
      check("t5_udf", {31'd0, underflow}, 32'd1);
      check("t5_sum", rd_sum, sum_m);
      rd_en = 1'b1; wr_en = 1'b1; wr_data = 8'h12;
      cyc();
      rd_en = 1'b0; wr_en = 1'b0;
      check("t5_level", {28'd0, level}, 32'd1);
      check("t5_rdata", {24'd0, rd_data}, 32'h12);
      check("t5_udf_hold", {31'd0, underflow}, 32'd1);
      check("t5_sum_hold", rd_sum, sum_m);
      err_clear = 1'b1;
      cyc();
      err_clear = 1'b0;
      check("t5_udf_clr", {31'd0, underflow}, 32'd0);
      // sum_clear together with a pop keeps only the popped word
      sum_clear = 1'b1;
      pop("t5_pop", 8'h12);
      sum_clear = 1'b0;
      check("t5_sumclr_pop", rd_sum, 32'h12);
      sum_m = 32'h12;

      // flush overrides a concurrent push
      push(8'hA1); push(8'hA2); push(8'hA3);
      check("t6_level3", {28'd0, level}, 32'd3);
      flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
      cyc();
      flush = 1'b0; wr_en = 1'b0;
      check("t6_level", {28'd0, level}, 32'd0);
      check("t6_empty", {31'd0, empty}, 32'd1);
      check("t6_sum", rd_sum, 32'd0);
      check("t6_ovf", {31'd0, overflow}, 32'd0);
      check("t6_rdata", {24'd0, rd_data}, 32'd0);
      push(8'h01);
      check("t6_after_level", {28'd0, level}, 32'd1);
      check("t6_after_rdata", {24'd0, rd_data}, 32'h01);

      // reset mid-transfer discards contents
      push(8'h02);
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      check("t7_level", {28'd0, level}, 32'd0);
      check("t7_empty", {31'd0, empty}, 32'd1);
      check("t7_rdata", {24'd0, rd_data}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
